pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage core.
- Produces the write_enable/flush pair for each of the four stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB), plus the PC write enable and the EX-stage operand forwarding selects.
- Resolves load-use hazards, taken-branch/jump redirects and multi-cycle MDU stalls.
- Stage registers sample its outputs on the same Clk edge; all outputs are combinational from the inputs and the internal state.

Parameters:
- MDU_TIMEOUT, 64, maximum MDU_BUSY cycles before forced return to RUN; range 2..65535.
- CNT_W, 32, width of the performance counters.

Ports:
- Clk  in  1  core clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads that source
- ex_rs1, ex_rs2  in  5 each  source registers held in ID/EX
- ex_rd  in  5  destination register in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_redirect  in  1  taken branch/jump resolved in EX
- ex_mdu_start  in  1  EX holds a multi-cycle mul/div; pulse on first EX cycle
- mdu_done  in  1  MDU result valid this cycle
- mem_rd, wb_rd  in  5 each  destination registers in MEM / WB
- mem_reg_write, wb_reg_write  in  1 each  MEM / WB instruction writes rd
- pc_write  out  1  PC update enable
- ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, exmem_flush, memwb_we, memwb_flush  out  1 each  stage-register controls
- fwd_a, fwd_b  out  2 each  00 = register file, 01 = EX/MEM, 10 = MEM/WB
- mdu_timeout  out  1  sticky error flag
- stall_cnt, flush_cnt  out  CNT_W each  performance counters (see Optional Feature)

Behaviour:
- Reset (Rst_n low, asynchronous):
  - state = RUN; mdu_timeout = 0; counters = 0; busy-cycle count = 0.
  - Outputs while in reset: every we = 0, every flush = 0, pc_write = 0, fwd_a = fwd_b = 00.
  - Rst_n asserted mid-MDU_BUSY returns the state to RUN immediately.
- FSM states: RUN, MDU_BUSY.
- RUN, by priority, highest first:
  1. ex_mdu_start: PC, IF/ID and ID/EX we = 0; exmem_flush = 1; memwb_we = 1. Next state = MDU_BUSY unless mdu_done is also high this cycle; in that case treat as a 1-cycle op: exmem_we = 1, no flush, stay in RUN.
  2. ex_redirect: pc_write = 1; ifid_flush = 1; idex_flush = 1; exmem_we = memwb_we = 1. Overrides load-use, because the ID instruction is squashed.
  3. Load-use: ex_mem_read, ex_rd != 0, and (id_use_rs1 and id_rs1 == ex_rd, or id_use_rs2 and id_rs2 == ex_rd). Then pc_write = 0; ifid_we = 0; idex_flush = 1 (bubble); exmem_we = memwb_we = 1. Lasts exactly one cycle; the next cycle is covered by forwarding.
  4. Otherwise: all we = 1, all flush = 0, pc_write = 1.
- MDU_BUSY:
  - PC, IF/ID and ID/EX we = 0; exmem_flush = 1; memwb_we = 1.
  - ex_redirect and load-use are ignored.
  - Busy-cycle counter increments each cycle.
  - mdu_done: this cycle exmem_we = 1, exmem_flush = 0, stages upstream of EX/MEM stay held. Next state = RUN; counter cleared.
  - Counter reaches MDU_TIMEOUT - 1 without mdu_done: set mdu_timeout (sticky until reset); behave as the mdu_done cycle; next state = RUN.
- Flush takes precedence over we inside a stage register; this unit never drives both high for the same register.
- Forwarding (combinational, independent of state), shown for fwd_a; fwd_b is identical using ex_rs2:
  - 01 if mem_reg_write, mem_rd != 0 and mem_rd == ex_rs1.
  - Else 10 if wb_reg_write, wb_rd != 0 and wb_rd == ex_rs1.
  - Else 00.
  - MEM takes priority over WB; x0 is never forwarded.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on every post-reset cycle with pc_write = 0.
  - flush_cnt increments on every cycle with ifid_flush or idex_flush = 1.
  - Both wrap modulo 2^CNT_W and reset to 0.
- Undefined: no counter flops; stall_cnt and flush_cnt are tied to 0.

Test Plan:
- Load-use: ex_mem_read = 1, ex_rd = 5, id_rs1 = 5, id_use_rs1 = 1 -> one cycle of pc_write = 0, ifid_we = 0, idex_flush = 1; following cycle all we = 1.
- Load to x0: ex_rd = 0, id_rs1 = 0 -> no stall; fwd_a = 00 even with mem_rd = 0, mem_reg_write = 1.
- Redirect plus load-use in the same cycle -> pc_write = 1, ifid_flush = idex_flush = 1, ifid_we irrelevant; flush_cnt += 1 with PIPE_PERF_CNT_EN defined.
- Forward priority: ex_rs1 = 7, mem_rd = 7, wb_rd = 7, both reg_write = 1 -> fwd_a = 01; clear mem_reg_write -> fwd_a = 10.
- MDU: ex_mdu_start, mdu_done after 4 cycles -> 5 cycles with pc_write = 0 and exmem_flush = 1 for the first 4, exmem_we = 1 on the done cycle, then RUN; stall_cnt = 5.
- Timeout: MDU_TIMEOUT = 8, mdu_done never asserted -> return to RUN after 8 busy cycles, mdu_timeout = 1 and held; Rst_n low mid-busy clears it asynchronously.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Pipeline control unit for the 5-stage core. Produces the
//            write-enable / flush pair for each stage register (IF/ID, ID/EX,
//            EX/MEM, MEM/WB), the PC write enable and the EX-stage operand
//            forwarding selects. Resolves load-use hazards, taken
//            branch/jump redirects and multi-cycle MDU stalls.
//            All control outputs are combinational from the inputs and the
//            internal state, so the stage registers sample them on the same
//            clock edge.
// Option   : define PIPE_PERF_CNT_EN to build the stall/flush performance
//            counters; otherwise stall_cnt_o / flush_cnt_o are tied to zero.
// Ports    :
//   clk_i, rst_ni            core clock (rising edge), async active-low reset
//   id_rs1_i/id_rs2_i        ID source registers, id_use_rs*_i read flags
//   ex_rs1_i/ex_rs2_i/ex_rd_i  ID/EX sources and EX destination
//   ex_mem_read_i            EX instruction is a load
//   ex_redirect_i            taken branch/jump resolved in EX
//   ex_mdu_start_i           first EX cycle of a multi-cycle mul/div
//   mdu_done_i               MDU result valid this cycle
//   mem_rd_i/wb_rd_i, mem_reg_write_i/wb_reg_write_i  MEM/WB writers
//   pc_write_o               PC update enable
//   *_we_o / *_flush_o       stage-register controls
//   fwd_a_o/fwd_b_o          00 = regfile, 01 = EX/MEM, 10 = MEM/WB
//   mdu_timeout_o            sticky MDU timeout error flag
//   stall_cnt_o/flush_cnt_o  performance counters
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
   parameter int unsigned MDU_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic             id_use_rs1_i,
   input  logic             id_use_rs2_i,
   input  logic [4:0]       ex_rs1_i,
   input  logic [4:0]       ex_rs2_i,
   input  logic [4:0]       ex_rd_i,
   input  logic             ex_mem_read_i,
   input  logic             ex_redirect_i,
   input  logic             ex_mdu_start_i,
   input  logic             mdu_done_i,
   input  logic [4:0]       mem_rd_i,
   input  logic [4:0]       wb_rd_i,
   input  logic             mem_reg_write_i,
   input  logic             wb_reg_write_i,
   output logic             pc_write_o,
   output logic             ifid_we_o,
   output logic             ifid_flush_o,
   output logic             idex_we_o,
   output logic             idex_flush_o,
   output logic             exmem_we_o,
   output logic             exmem_flush_o,
   output logic             memwb_we_o,
   output logic             memwb_flush_o,
   output logic [1:0]       fwd_a_o,
   output logic [1:0]       fwd_b_o,
   output logic             mdu_timeout_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   // MDU_TIMEOUT is bounded to 65535, so 16 bits always hold the busy count.
   localparam int unsigned      BUSY_W    = 16;
   localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(MDU_TIMEOUT - 1);
   localparam logic [BUSY_W-1:0] BUSY_ONE  = {{(BUSY_W-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      ST_RUN      = 1'b0,
      ST_MDU_BUSY = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [BUSY_W-1:0] busy_cnt_q, busy_cnt_d;
   logic              timeout_q, timeout_d;
   logic              load_use;

   // Load into a register the ID instruction really reads; x0 never hazards.
   assign load_use = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                     ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                      (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

   // MEM result is younger than WB, so it wins; x0 is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] m_rd,
                                          input logic       m_we,
                                          input logic [4:0] w_rd,
                                          input logic       w_we);
      logic [1:0] sel;
      sel = 2'b00;
      if (m_we && (m_rd != 5'd0) && (m_rd == rs)) begin
         sel = 2'b01;
      end else if (w_we && (w_rd != 5'd0) && (w_rd == rs)) begin
         sel = 2'b10;
      end
      return sel;
   endfunction

   always_comb begin
      state_d       = state_q;
      busy_cnt_d    = busy_cnt_q;
      timeout_d     = timeout_q;
      pc_write_o    = 1'b0;
      ifid_we_o     = 1'b0;
      ifid_flush_o  = 1'b0;
      idex_we_o     = 1'b0;
      idex_flush_o  = 1'b0;
      exmem_we_o    = 1'b0;
      exmem_flush_o = 1'b0;
      memwb_we_o    = 1'b0;
      memwb_flush_o = 1'b0;
      fwd_a_o       = fwd_sel(ex_rs1_i, mem_rd_i, mem_reg_write_i,
                              wb_rd_i, wb_reg_write_i);
      fwd_b_o       = fwd_sel(ex_rs2_i, mem_rd_i, mem_reg_write_i,
                              wb_rd_i, wb_reg_write_i);

      case (state_q)
         ST_RUN: begin
            if (ex_mdu_start_i) begin
               // Front end and EX held; the older MEM instruction drains.
               memwb_we_o = 1'b1;
               if (mdu_done_i) begin
                  // Single-cycle op: result is written straight away.
                  exmem_we_o = 1'b1;
               end else begin
                  exmem_flush_o = 1'b1;
                  state_d       = ST_MDU_BUSY;
                  busy_cnt_d    = '0;
               end
            end else if (ex_redirect_i) begin
               // The ID instruction is squashed, so a load-use is moot.
               pc_write_o   = 1'b1;
               ifid_flush_o = 1'b1;
               idex_flush_o = 1'b1;
               exmem_we_o   = 1'b1;
               memwb_we_o   = 1'b1;
            end else if (load_use) begin
               // Hold PC and IF/ID, insert a bubble into ID/EX.
               idex_flush_o = 1'b1;
               exmem_we_o   = 1'b1;
               memwb_we_o   = 1'b1;
            end else begin
               pc_write_o = 1'b1;
               ifid_we_o  = 1'b1;
               idex_we_o  = 1'b1;
               exmem_we_o = 1'b1;
               memwb_we_o = 1'b1;
            end
         end

         ST_MDU_BUSY: begin
            memwb_we_o = 1'b1;
            if (mdu_done_i || (busy_cnt_q == BUSY_LAST)) begin
               // Completion (or forced completion) cycle: capture EX result.
               exmem_we_o = 1'b1;
               state_d    = ST_RUN;
               busy_cnt_d = '0;
               if (!mdu_done_i) begin
                  timeout_d = 1'b1;
               end
            end else begin
               exmem_flush_o = 1'b1;
               busy_cnt_d    = busy_cnt_q + BUSY_ONE;
            end
         end

         default: begin
            state_d = ST_RUN;
         end
      endcase

      // Every control is quiet while reset is asserted.
      if (!rst_ni) begin
         pc_write_o    = 1'b0;
         ifid_we_o     = 1'b0;
         ifid_flush_o  = 1'b0;
         idex_we_o     = 1'b0;
         idex_flush_o  = 1'b0;
         exmem_we_o    = 1'b0;
         exmem_flush_o = 1'b0;
         memwb_we_o    = 1'b0;
         memwb_flush_o = 1'b0;
         fwd_a_o       = 2'b00;
         fwd_b_o       = 2'b00;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_RUN;
         busy_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         busy_cnt_q <= busy_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign mdu_timeout_o = timeout_q;

`ifdef PIPE_PERF_CNT_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (!pc_write_o) begin
            stall_cnt_q <= stall_cnt_q + CNT_ONE;
         end
         if (ifid_flush_o || idex_flush_o) begin
            flush_cnt_q <= flush_cnt_q + CNT_ONE;
         end
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`else
   assign stall_cnt_o = '0;
   assign flush_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Self-checking bench for pipe_hazard_ctrl. Combinational RUN
//            behaviour is exercised from a vector table; MDU completion,
//            MDU timeout and asynchronous reset are hand-written sequences.
//            Expected control words are queued when stimulus is driven and
//            compared on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

   localparam int unsigned TB_TIMEOUT = 8;
   localparam int unsigned TB_CNT_W   = 32;

   logic clk, rst_n;
   logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, ex_mdu_start;
   logic mdu_done, mem_reg_write, wb_reg_write;
   logic pc_write, ifid_we, ifid_flush, idex_we, idex_flush;
   logic exmem_we, exmem_flush, memwb_we, memwb_flush, mdu_timeout;
   logic [1:0] fwd_a, fwd_b;
   logic [TB_CNT_W-1:0] stall_cnt, flush_cnt;

   pipe_hazard_ctrl #(.MDU_TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
      .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
      .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2), .ex_rd_i(ex_rd),
      .ex_mem_read_i(ex_mem_read), .ex_redirect_i(ex_redirect),
      .ex_mdu_start_i(ex_mdu_start), .mdu_done_i(mdu_done),
      .mem_rd_i(mem_rd), .wb_rd_i(wb_rd),
      .mem_reg_write_i(mem_reg_write), .wb_reg_write_i(wb_reg_write),
      .pc_write_o(pc_write), .ifid_we_o(ifid_we), .ifid_flush_o(ifid_flush),
      .idex_we_o(idex_we), .idex_flush_o(idex_flush),
      .exmem_we_o(exmem_we), .exmem_flush_o(exmem_flush),
      .memwb_we_o(memwb_we), .memwb_flush_o(memwb_flush),
      .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .mdu_timeout_o(mdu_timeout),
      .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] id_rs1;
      logic [4:0] id_rs2;
      logic       use1;
      logic       use2;
      logic [4:0] ex_rs1;
      logic [4:0] ex_rs2;
      logic [4:0] ex_rd;
      logic       mem_read;
      logic       redirect;
      logic       mdu_start;
      logic       mdu_done;
      logic [4:0] mem_rd;
      logic [4:0] wb_rd;
      logic       mem_rw;
      logic       wb_rw;
   } stim_t;

   typedef struct {
      string       name;
      stim_t       stim;
      logic [12:0] exp;
   } vec_t;

   typedef struct {
      string       name;
      logic [12:0] exp;
   } sb_t;

   vec_t tbl[$];
   sb_t  sb_q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   model_stall = 0;
   int   model_flush = 0;

   // Control word: {pc, ifid_we, ifid_fl, idex_we, idex_fl, exmem_we,
   //                exmem_fl, memwb_we, memwb_fl, fwd_a[1:0], fwd_b[1:0]}
   logic [12:0] act;
   assign act = {pc_write, ifid_we, ifid_flush, idex_we, idex_flush,
                 exmem_we, exmem_flush, memwb_we, memwb_flush, fwd_a, fwd_b};

   localparam logic [12:0] E_RUN   = 13'b1_10_10_10_10_0000;
   localparam logic [12:0] E_LU    = 13'b0_00_01_10_10_0000;
   localparam logic [12:0] E_RED   = 13'b1_01_01_10_10_0000;
   localparam logic [12:0] E_MDU   = 13'b0_00_00_01_10_0000;
   localparam logic [12:0] E_MDONE = 13'b0_00_00_10_10_0000;
   localparam logic [12:0] E_ZERO  = 13'b0;

   task automatic drive(input stim_t s);
      id_rs1 = s.id_rs1;       id_rs2 = s.id_rs2;
      id_use_rs1 = s.use1;     id_use_rs2 = s.use2;
      ex_rs1 = s.ex_rs1;       ex_rs2 = s.ex_rs2;   ex_rd = s.ex_rd;
      ex_mem_read = s.mem_read; ex_redirect = s.redirect;
      ex_mdu_start = s.mdu_start; mdu_done = s.mdu_done;
      mem_rd = s.mem_rd;       wb_rd = s.wb_rd;
      mem_reg_write = s.mem_rw; wb_reg_write = s.wb_rw;
   endtask

   task automatic check_out();
      sb_t e;
      n_vec++;
      if (sb_q.size() == 0) begin
         n_bad++;
         $display("FAIL scoreboard-empty: got %b required an expectation", act);
      end else begin
         e = sb_q.pop_front();
         if (act !== e.exp) begin
            n_bad++;
            $display("FAIL %s: got %b required %b", e.name, act, e.exp);
         end
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] got,
                            input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d required %0d", name, got, exp);
      end
   endtask

   // Drive one cycle of stimulus (called just after a rising edge),
   // compare on the falling edge, return just after the next rising edge.
   task automatic apply(input string name, input stim_t s,
                        input logic [12:0] exp);
      drive(s);
      sb_q.push_back('{name, exp});
      if (!exp[12]) model_stall++;
      if (exp[10] || exp[8]) model_flush++;
      @(negedge clk);
      check_out();
      @(posedge clk);
      #1;
   endtask

   task automatic check_perf(input string tag);
      int es, ef;
`ifdef PIPE_PERF_CNT_EN
      es = model_stall;
      ef = model_flush;
`else
      es = 0;
      ef = 0;
`endif
      check_val({tag, "-stall_cnt"}, stall_cnt, es);
      check_val({tag, "-flush_cnt"}, flush_cnt, ef);
   endtask

   task automatic add(input string name, input stim_t s, input logic [12:0] e);
      tbl.push_back('{name, s, e});
   endtask

   initial begin
      stim_t s;

      // ---------------- vector table (all in RUN) ----------------
      s = '0;                                           add("idle", s, E_RUN);
      s = '0; s.mem_read = 1; s.ex_rd = 5; s.id_rs1 = 5; s.use1 = 1;
      add("load-use-rs1", s, E_LU);
      s.mem_read = 0;                                   add("after-load-use", s, E_RUN);
      s = '0; s.mem_read = 1; s.ex_rd = 9; s.id_rs2 = 9; s.use2 = 1;
      add("load-use-rs2", s, E_LU);
      s.use2 = 0;                                       add("no-use-flag", s, E_RUN);
      s = '0; s.mem_read = 1; s.use1 = 1; s.mem_rw = 1; // rd = rs1 = mem_rd = x0
      add("load-x0", s, E_RUN);
      s = '0; s.ex_rd = 4; s.id_rs1 = 4; s.use1 = 1;    add("not-a-load", s, E_RUN);
      s = '0; s.mem_read = 1; s.ex_rd = 5; s.id_rs1 = 5; s.use1 = 1; s.redirect = 1;
      add("redirect-over-load-use", s, E_RED);
      s = '0; s.redirect = 1;                           add("redirect", s, E_RED);
      s = '0; s.ex_rs1 = 7; s.mem_rd = 7; s.wb_rd = 7; s.mem_rw = 1; s.wb_rw = 1;
      add("fwd-a-mem-prio", s, E_RUN | 13'b01_00);
      s.mem_rw = 0;                                     add("fwd-a-wb", s, E_RUN | 13'b10_00);
      s = '0; s.ex_rs1 = 3; s.wb_rd = 3; s.wb_rw = 1; s.ex_rs2 = 12; s.mem_rd = 12; s.mem_rw = 1;
      add("fwd-a-wb-b-mem", s, E_RUN | 13'b10_01);
      s = '0; s.ex_rs2 = 6; s.wb_rd = 6; s.wb_rw = 1;   add("fwd-b-wb", s, E_RUN | 13'b00_10);
      s = '0; s.ex_rs2 = 6; s.mem_rd = 6; s.wb_rd = 6;  add("fwd-no-write", s, E_RUN);
      s = '0; s.mdu_start = 1; s.mdu_done = 1;          add("mdu-1cycle", s, E_MDONE);
      s = '0;                                           add("after-mdu-1cycle", s, E_RUN);

      // ---------------- reset state ----------------
      rst_n = 1'b0;
      s = '0; s.mem_read = 1; s.ex_rd = 5; s.id_rs1 = 5; s.use1 = 1;
      s.ex_rs1 = 7; s.mem_rd = 7; s.mem_rw = 1;
      drive(s);
      repeat (2) @(posedge clk);
      sb_q.push_back('{"reset-outputs", E_ZERO});
      @(negedge clk);
      check_out();
      check_val("reset-mdu_timeout", {31'd0, mdu_timeout}, 32'd0);
      check_val("reset-stall_cnt", stall_cnt, 32'd0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ---------------- table ----------------
      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i].name, tbl[i].stim, tbl[i].exp);
      end
      check_perf("table");

      // ---------------- MDU: done after 4 cycles ----------------
      s = '0; s.mdu_start = 1;                          apply("mdu-start", s, E_MDU);
      s = '0;                                           apply("mdu-busy1", s, E_MDU);
      s = '0; s.redirect = 1; s.mem_read = 1; s.ex_rd = 2; s.id_rs1 = 2; s.use1 = 1;
      apply("mdu-busy-ignores-hazards", s, E_MDU);
      s = '0; s.ex_rs1 = 8; s.mem_rd = 8; s.mem_rw = 1; apply("mdu-busy-fwd", s, E_MDU | 13'b01_00);
      s = '0; s.mdu_done = 1;                           apply("mdu-done", s, E_MDONE);
      s = '0;                                           apply("mdu-back-to-run", s, E_RUN);
      check_val("mdu-no-timeout", {31'd0, mdu_timeout}, 32'd0);
      check_perf("mdu");

      // ---------------- MDU timeout ----------------
      s = '0; s.mdu_start = 1;                          apply("to-start", s, E_MDU);
      s = '0;
      for (int c = 1; c < TB_TIMEOUT; c++) begin
         apply($sformatf("to-busy%0d", c), s, E_MDU);
      end
      check_val("to-flag-not-yet", {31'd0, mdu_timeout}, 32'd0);
      apply("to-forced-done", s, E_MDONE);
      check_val("to-flag-set", {31'd0, mdu_timeout}, 32'd1);
      apply("to-back-to-run", s, E_RUN);
      s.mdu_start = 1; s.mdu_done = 1;                  apply("to-mdu-1cycle", s, E_MDONE);
      check_val("to-flag-sticky", {31'd0, mdu_timeout}, 32'd1);
      check_perf("timeout");

      // ---------------- async reset mid-busy ----------------
      s = '0; s.mdu_start = 1;                          apply("rst-mdu-start", s, E_MDU);
      s = '0;                                           apply("rst-mdu-busy", s, E_MDU);
      #2 rst_n = 1'b0;
      #1;
      sb_q.push_back('{"async-reset-outputs", E_ZERO});
      check_out();
      check_val("async-reset-timeout", {31'd0, mdu_timeout}, 32'd0);
      model_stall = 0;
      model_flush = 0;
      check_perf("async-reset");
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      s = '0;                                           apply("after-reset-run", s, E_RUN);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
